fc_in_buffer: RTL and testbench

Serial-to-parallel, double-buffered activation collector that sits directly upstream of the combinational fully-connected `layer` block. It accepts one signed `WIDTH`-bit activation per cycle over a valid/ready stream and assembles `IN` activations into a vector. It presents that vector as the `x[0:IN-1]` array the layer consumes. Two banks (ping-pong) allow a new frame to fill while the previous vector is held stable for the layer and its downstream capture.

---
 rtl/fc_pkg.sv | 7 +
 rtl/fc_buf_bank.sv | 31 +++
 rtl/fc_in_buffer.sv | 88 ++++++++
 tb/tb_fc_in_buffer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// rtl/fc_pkg.sv - shared defaults and index type for the fully-connected datapath
package fc_pkg;
  localparam int FC_IN    = 128;
  localparam int FC_WIDTH = 8;

  typedef logic [$clog2(FC_IN)-1:0] fc_idx_t;
endpackage

// File: rtl/fc_buf_bank.sv
// rtl/fc_buf_bank.sv - one IN x WIDTH activation bank with indexed write and single-cycle clear
module fc_buf_bank
  import fc_pkg::*;
#(
  parameter int WIDTH = FC_WIDTH,
  parameter int IN    = FC_IN,
  localparam int IDX_W = $clog2(IN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [WIDTH-1:0] din,
  input  logic             clr,
  output logic [WIDTH-1:0] dout [0:IN-1]
);

  logic [WIDTH-1:0] mem [0:IN-1];

  // Clear wins over write; the top never targets one bank with both.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int i = 0; i < IN; i++) mem[i] <= '0;
    end else if (we) begin
      mem[idx] <= din;
    end
  end

  assign dout = mem;

endmodule

// File: rtl/fc_in_buffer.sv
// rtl/fc_in_buffer.sv - ping-pong serial-to-parallel activation collector feeding the fc layer
module fc_in_buffer
  import fc_pkg::*;
#(
  parameter int WIDTH = FC_WIDTH,
  parameter int IN    = FC_IN,
  localparam int IDX_W = $clog2(IN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_last,
  output logic [WIDTH-1:0] x [0:IN-1],
  output logic             x_valid,
  input  logic             x_ready,
  output logic             err
);

  logic [1:0]       full;
  logic             wr_bank;
  logic             rd_bank;
  logic [IDX_W-1:0] idx;

  logic             accept;
  logic             at_end;
  logic             close;
  logic             release_vec;
  logic [WIDTH-1:0] dout0 [0:IN-1];
  logic [WIDTH-1:0] dout1 [0:IN-1];

  assign s_ready     = !full[wr_bank];
  assign x_valid     = full[rd_bank];
  assign accept      = s_valid && s_ready;
  assign at_end      = (idx == IDX_W'(IN - 1));
  assign close       = accept && (s_last || at_end);
  assign release_vec = x_valid && x_ready;

  // Close and release always touch different banks: the write bank is empty, the read bank full.
  always_ff @(posedge clk) begin
    if (rst) begin
      full    <= 2'b00;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      idx     <= '0;
      err     <= 1'b0;
    end else begin
      if (accept) begin
        idx <= close ? '0 : idx + 1'b1;
        if (s_last != at_end) err <= 1'b1;
      end
      if (close) begin
        full[wr_bank] <= 1'b1;
        wr_bank       <= !wr_bank;
      end
      if (release_vec) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= !rd_bank;
      end
    end
  end

  fc_buf_bank #(.WIDTH(WIDTH), .IN(IN)) u_bank0 (
    .clk  (clk),
    .rst  (rst),
    .we   (accept && !wr_bank),
    .idx  (idx),
    .din  (s_data),
    .clr  (release_vec && !rd_bank),
    .dout (dout0)
  );

  fc_buf_bank #(.WIDTH(WIDTH), .IN(IN)) u_bank1 (
    .clk  (clk),
    .rst  (rst),
    .we   (accept && wr_bank),
    .idx  (idx),
    .din  (s_data),
    .clr  (release_vec && rd_bank),
    .dout (dout1)
  );

  always_comb begin
    for (int i = 0; i < IN; i++) x[i] = rd_bank ? dout1[i] : dout0[i];
  end

endmodule

// File: tb/tb_fc_in_buffer.sv
// tb/tb_fc_in_buffer.sv - randomized and directed self-checking bench for fc_in_buffer
module tb_fc_in_buffer;
  localparam int W = 8;
  localparam int N = 128;

  typedef logic [W-1:0] vec_t [0:N-1];

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [W-1:0] s_data = '0;
  logic         s_last = 1'b0;
  logic [W-1:0] x [0:N-1];
  logic         x_valid;
  logic         x_ready = 1'b0;
  logic         err;

  int tests = 0;
  int fails = 0;

  // Reference: queue of completed vectors, the partial frame, beat index, sticky error.
  vec_t mq[$];
  vec_t partial;
  int   midx;
  logic merr;

  fc_in_buffer #(.WIDTH(W), .IN(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .x       (x),
    .x_valid (x_valid),
    .x_ready (x_ready),
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < N; i++) partial[i] = '0;
    midx = 0;
    merr = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic [W-1:0] d, input logic l,
                            input logic xr, input logic r);
    logic rel;
    logic acc;
    if (r) begin
      model_reset();
    end else begin
      rel = (mq.size() > 0) && xr;
      acc = v && (mq.size() < 2);
      if (rel) void'(mq.pop_front());
      if (acc) begin
        partial[midx] = d;
        if (l != (midx == N - 1)) merr = 1'b1;
        if (l || midx == N - 1) begin
          mq.push_back(partial);
          for (int i = 0; i < N; i++) partial[i] = '0;
          midx = 0;
        end else begin
          midx++;
        end
      end
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_model();
    vec_t ex;
    int   bad;
    ex = (mq.size() > 0) ? mq[0] : partial;
    check_bit("s_ready", s_ready, mq.size() < 2);
    check_bit("x_valid", x_valid, mq.size() > 0);
    check_bit("err", err, merr);
    bad = -1;
    for (int i = 0; i < N; i++) if (bad < 0 && x[i] !== ex[i]) bad = i;
    tests++;
    if (bad >= 0) begin
      fails++;
      $display("FAIL x[%0d]: got %0h expected %0h at %0t", bad, x[bad], ex[bad], $time);
    end
  endtask

  // Inputs are driven at the falling edge; outputs are checked at the next falling edge.
  task automatic cycle(input logic v, input logic [W-1:0] d, input logic l,
                       input logic xr, input logic r);
    s_valid = v; s_data = d; s_last = l; x_ready = xr; rst = r;
    @(posedge clk);
    model_step(v, d, l, xr, r);
    @(negedge clk);
    check_model();
  endtask

  task automatic do_reset();
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
  endtask

  task automatic send_beat(input logic [W-1:0] d, input logic l, input logic auto_rel);
    int   budget;
    logic a;
    budget = 0;
    forever begin
      a = (mq.size() < 2);
      cycle(1'b1, d, l, auto_rel && (mq.size() > 0), 1'b0);
      if (a) break;
      budget++;
      if (budget > 300) begin
        tests++; fails++;
        $display("FAIL send_timeout: got stalled expected accept");
        break;
      end
    end
  endtask

  task automatic send_frame(input int nbeats, input int last_at, input int base,
                            input logic auto_rel);
    for (int k = 0; k < nbeats; k++) send_beat(W'(base + k), k == last_at, auto_rel);
  endtask

  task automatic idle(input logic xr);
    cycle(1'b0, '0, 1'b0, xr, 1'b0);
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    check_lit("reset_s_ready", 32'(s_ready), 32'd1);
    check_lit("reset_x_valid", 32'(x_valid), 32'd0);
    check_lit("reset_err", 32'(err), 32'd0);

    // Nominal frame, consumer idle
    send_frame(N, N - 1, 0, 1'b0);
    check_lit("nominal_x_valid", 32'(x_valid), 32'd1);
    check_lit("nominal_x5", 32'(x[5]), 32'd5);
    check_lit("nominal_x127", 32'(x[127]), 32'd127);
    check_lit("nominal_err", 32'(err), 32'd0);

    // Backpressure: second frame fills the other bank, then input stalls
    send_frame(N, N - 1, 3, 1'b0);
    check_lit("bp_s_ready_low", 32'(s_ready), 32'd0);
    idle(1'b1);
    check_lit("bp_s_ready_high", 32'(s_ready), 32'd1);
    check_lit("bp_second_x0", 32'(x[0]), 32'd3);
    idle(1'b1);

    // Back-to-back frames with prompt release
    for (int f = 0; f < 3; f++) send_frame(N, N - 1, 17 * f, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Early last at beat 9
    do_reset();
    send_frame(9, -1, 1, 1'b0);
    send_beat(8'h7F, 1'b1, 1'b0);
    check_lit("early_x9", 32'(x[9]), 32'h7F);
    check_lit("early_x10", 32'(x[10]), 32'd0);
    check_lit("early_err", 32'(err), 32'd1);
    idle(1'b1);
    send_frame(N, N - 1, 0, 1'b0);
    check_lit("early_err_sticky", 32'(err), 32'd1);

    // Missing last: closes at beat 127, beat 128 opens a new frame
    do_reset();
    send_frame(N, -1, 0, 1'b0);
    check_lit("miss_x_valid", 32'(x_valid), 32'd1);
    check_lit("miss_err", 32'(err), 32'd1);
    send_beat(8'hA5, 1'b0, 1'b0);

    // Reset mid-frame
    do_reset();
    send_frame(50, -1, 9, 1'b0);
    do_reset();
    check_lit("midrst_s_ready", 32'(s_ready), 32'd1);
    check_lit("midrst_x_valid", 32'(x_valid), 32'd0);
    check_lit("midrst_x0", 32'(x[0]), 32'd0);
    check_lit("midrst_err", 32'(err), 32'd0);
    send_frame(N, N - 1, 100, 1'b0);
    check_lit("midrst_x0_after", 32'(x[0]), 32'd100);

    // Random traffic, sparse resets
    for (int c = 0; c < 4000; c++) begin
      cycle(1'($urandom_range(0, 3) != 0), W'($urandom), 1'($urandom_range(0, 39) == 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 999) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
